// File: rtl/pll_md_responder.sv
// MD-bus responder emulating a PLL configuration port: byte-wide register bank,
// registered read-back, and a lock model that drops on reset or reconfiguration.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ST_RST | PLL held in reset, lock low, counter cleared
// ST_WAIT| lock sequence running, counter counts up to LOCK_DELAY-1
// ST_LOCK| PLL locked, lock high until reset or a config write
module pll_md_responder #(
  parameter int         REG_DEPTH      = 32,
  parameter int         CFG_REGS       = 8,
  parameter int         LOCK_DELAY     = 64,
  parameter logic [7:0] MULTI_FAC_INIT = 8'd14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reset,
  input  logic [1:0] mdopc,
  input  logic       mdainc,
  input  logic [7:0] mdwdi,
  output logic [7:0] mdrdo,
  output logic       lock,
  output logic [7:0] multi_fac
);

  localparam int              AW       = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [AW:0]     CFG_LIM  = CFG_REGS[AW:0];
  localparam logic [AW-1:0]   ADDR_ONE = 1;
  localparam logic [15:0]     LOCK_TC  = 16'(LOCK_DELAY - 1);

  localparam logic [1:0] OPC_WRITE   = 2'b01;
  localparam logic [1:0] OPC_READ    = 2'b10;
  localparam logic [1:0] OPC_SETADDR = 2'b11;

  typedef enum logic [1:0] {ST_RST, ST_WAIT, ST_LOCK} state_t;

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic          r_lock;
  logic [7:0]    r_rdo;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_regs [REG_DEPTH];

  logic w_wr;
  logic w_rd;
  logic w_cfg_wr;

  assign w_wr     = (mdopc == OPC_WRITE);
  assign w_rd     = (mdopc == OPC_READ);
  assign w_cfg_wr = w_wr && ({1'b0, r_addr} < CFG_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rdo  <= '0;
      for (int i = 0; i < REG_DEPTH; i++)
        r_regs[i] <= (i == 0) ? MULTI_FAC_INIT : 8'h00;
    end else begin
      if (w_wr)
        r_regs[r_addr] <= mdwdi;
      if (w_rd)
        r_rdo <= r_regs[r_addr];
      if (mdopc == OPC_SETADDR)
        r_addr <= mdwdi[AW-1:0];
      else if ((w_wr || w_rd) && mdainc)
        r_addr <= r_addr + ADDR_ONE;
    end
  end

  // reset has priority over a simultaneous config write; the write itself still lands above
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_lock  <= 1'b0;
    end else if (reset) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_lock  <= 1'b0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
          r_lock  <= 1'b0;
        end
        ST_WAIT: begin
          if (w_cfg_wr) begin
            r_cnt <= '0;
          end else if (r_cnt == LOCK_TC) begin
            r_state <= ST_LOCK;
            r_lock  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_LOCK: begin
          if (w_cfg_wr) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RST;
          r_cnt   <= '0;
          r_lock  <= 1'b0;
        end
      endcase
    end
  end

  assign mdrdo     = r_rdo;
  assign lock      = r_lock;
  assign multi_fac = r_regs[0];

endmodule

// File: tb/tb_pll_md_responder.sv
// Bench for pll_md_responder: directed scenarios then random MD traffic, every
// cycle compared against a behavioural model of the register bank and lock timing.
module tb_pll_md_responder;

  localparam int         DEPTH = 32;
  localparam int         CFG   = 8;
  localparam int         DLY   = 64;
  localparam logic [7:0] MINIT = 8'd14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mdopc = 2'b00;
  logic       mdainc = 1'b0;
  logic [7:0] mdwdi = 8'h00;
  logic [7:0] mdrdo;
  logic       lock;
  logic [7:0] multi_fac;

  int checks = 0;
  int failures = 0;

  pll_md_responder #(
    .REG_DEPTH(DEPTH), .CFG_REGS(CFG), .LOCK_DELAY(DLY), .MULTI_FAC_INIT(MINIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reset(reset), .mdopc(mdopc), .mdainc(mdainc),
    .mdwdi(mdwdi), .mdrdo(mdrdo), .lock(lock), .multi_fac(multi_fac)
  );

  always #5 clk = ~clk;

  // reference model: register image, pointer, and "cycles since lock sequence began"
  int         m_addr;
  logic [7:0] m_regs [DEPTH];
  logic [7:0] m_rdo;
  bit         m_in_rst;
  int         m_since;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    m_regs[0] = MINIT;
    m_rdo = 8'h00;
    m_in_rst = 1'b1;
    m_since = 0;
  endtask

  task automatic model_edge(input logic [1:0] opc, input logic ainc,
                            input logic [7:0] wdi, input logic rst);
    bit cfg;
    cfg = (opc == 2'b01) && (m_addr < CFG);
    case (opc)
      2'b01: begin
        m_regs[m_addr] = wdi;
        if (ainc) m_addr = (m_addr + 1) % DEPTH;
      end
      2'b10: begin
        m_rdo = m_regs[m_addr];
        if (ainc) m_addr = (m_addr + 1) % DEPTH;
      end
      2'b11: m_addr = wdi % DEPTH;
      default: ;
    endcase
    if (rst) m_in_rst = 1'b1;
    else if (m_in_rst || cfg) begin
      m_in_rst = 1'b0;
      m_since = 0;
    end else if (m_since < 100000) m_since++;
  endtask

  function automatic logic model_lock();
    return !m_in_rst && (m_since >= DLY);
  endfunction

  task automatic step(input logic [1:0] opc, input logic ainc,
                      input logic [7:0] wdi, input logic rst);
    mdopc = opc; mdainc = ainc; mdwdi = wdi; reset = rst;
    @(posedge clk);
    model_edge(opc, ainc, wdi, rst);
    @(negedge clk);
    check("mdrdo", {8'h00, mdrdo}, {8'h00, m_rdo});
    check("lock", {15'h0, lock}, {15'h0, model_lock()});
    check("multi_fac", {8'h00, multi_fac}, {8'h00, m_regs[0]});
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_multi_fac", {8'h00, multi_fac}, 16'h000e);
    check("rst_mdrdo", {8'h00, mdrdo}, 16'h0000);
    check("rst_lock", {15'h0, lock}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // lock rises exactly DLY edges after the first edge after release
    nops(DLY);
    check("lock_pre", {15'h0, lock}, 16'h0000);
    nops(1);
    check("lock_rise", {15'h0, lock}, 16'h0001);

    // write/readback at a config address
    step(2'b11, 1'b0, 8'd5, 1'b0);
    step(2'b01, 1'b0, 8'ha5, 1'b0);
    check("cfg_wr_lock_drop", {15'h0, lock}, 16'h0000);
    step(2'b11, 1'b0, 8'd5, 1'b0);
    step(2'b10, 1'b0, 8'h00, 1'b0);
    check("readback_a5", {8'h00, mdrdo}, 16'h00a5);

    // burst with wrap 30,31,0
    step(2'b11, 1'b0, 8'd30, 1'b0);
    step(2'b01, 1'b1, 8'h11, 1'b0);
    step(2'b01, 1'b1, 8'h22, 1'b0);
    step(2'b01, 1'b1, 8'h33, 1'b0);
    check("wrap_multi_fac", {8'h00, multi_fac}, 16'h0033);
    step(2'b11, 1'b0, 8'd30, 1'b0);
    step(2'b10, 1'b1, 8'h00, 1'b0);
    check("burst_rd0", {8'h00, mdrdo}, 16'h0011);
    step(2'b10, 1'b1, 8'h00, 1'b0);
    check("burst_rd1", {8'h00, mdrdo}, 16'h0022);
    step(2'b10, 1'b1, 8'h00, 1'b0);
    check("burst_rd2", {8'h00, mdrdo}, 16'h0033);

    // non-config write while locked
    nops(DLY + 2);
    check("locked_again", {15'h0, lock}, 16'h0001);
    step(2'b11, 1'b0, 8'd12, 1'b0);
    step(2'b01, 1'b0, 8'h7f, 1'b0);
    check("noncfg_lock", {15'h0, lock}, 16'h0001);
    check("noncfg_multi_fac", {8'h00, multi_fac}, 16'h0033);

    // reset and config write in the same cycle while in WAIT
    step(2'b11, 1'b0, 8'd0, 1'b0);
    step(2'b01, 1'b0, 8'h44, 1'b0);
    nops(3);
    step(2'b01, 1'b0, 8'h55, 1'b1);
    check("simul_multi_fac", {8'h00, multi_fac}, 16'h0055);
    check("simul_lock", {15'h0, lock}, 16'h0000);
    nops(DLY);
    check("simul_lock_pre", {15'h0, lock}, 16'h0000);
    nops(1);
    check("simul_lock_rise", {15'h0, lock}, 16'h0001);

    // async reset in the middle of a burst
    step(2'b11, 1'b0, 8'd3, 1'b0);
    step(2'b01, 1'b1, 8'haa, 1'b0);
    step(2'b01, 1'b1, 8'hbb, 1'b0);
    mdopc = 2'b01; mdwdi = 8'hcc;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_multi_fac", {8'h00, multi_fac}, 16'h000e);
    check("arst_lock", {15'h0, lock}, 16'h0000);
    check("arst_mdrdo", {8'h00, mdrdo}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b10, 1'b0, 8'h00, 1'b0);
    check("arst_rd_addr0", {8'h00, mdrdo}, 16'h000e);
    step(2'b11, 1'b0, 8'd3, 1'b0);
    step(2'b10, 1'b0, 8'h00, 1'b0);
    check("arst_rd_addr3", {8'h00, mdrdo}, 16'h0000);

    // random traffic, biased toward non-config addresses so lock is reached
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] opc;
      logic [7:0] wdi;
      logic       rst;
      opc = 2'($urandom_range(0, 3));
      wdi = 8'($urandom);
      if (opc == 2'b11 && $urandom_range(0, 9) < 8)
        wdi = 8'($urandom_range(CFG, DEPTH - 1)) | (8'($urandom) & 8'he0);
      rst = ($urandom_range(0, 299) == 0);
      step(opc, 1'($urandom), wdi, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
